// File: rtl/axi3_burst_addr_gen.sv
// rtl/axi3_burst_addr_gen.sv - AXI3 burst address, strobe and response generator
// One command in, len+1 registered beats out; illegal bursts still run to completion as SLVERR.
module axi3_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [ADDR_WIDTH-1:0]   beat_addr,
  output logic [DATA_WIDTH/8-1:0] beat_strb,
  output logic                    beat_last,
  output logic [LEN_WIDTH-1:0]    beat_idx,
  output logic [ID_WIDTH-1:0]     beat_id,
  output logic [1:0]              beat_resp
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] XBURST_FIXED    = 2'b00;
  localparam logic [1:0] XBURST_INCR     = 2'b01;
  localparam logic [1:0] XBURST_WRAP     = 2'b10;
  localparam logic [1:0] XBURST_RESERVED = 2'b11;
  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [1:0] RESP_SLVERR     = 2'b10;
  localparam logic [0:0] IDLE            = 1'b0;
  localparam logic [0:0] ACTIVE          = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(STRB_W - 1);

  // Lanes from the address's lane offset to the end of its size-aligned container.
  function automatic logic [STRB_W-1:0] lane_strb(input logic [ADDR_WIDTH-1:0] addr,
                                                  input logic [ADDR_WIDTH-1:0] bytes);
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] top;
    logic [STRB_W-1:0]     s;
    off = addr & LANE_MASK;
    top = (off & ~(bytes - ONE)) + bytes - ONE;
    for (int i = 0; i < STRB_W; i++)
      s[i] = (ADDR_WIDTH'(i) >= off) && (ADDR_WIDTH'(i) <= top);
    return s;
  endfunction

  logic [0:0]            state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ADDR_WIDTH-1:0] lower_q;
  logic [ADDR_WIDTH-1:0] span_q;

  logic [ADDR_WIDTH-1:0] c_bytes, c_beats, c_aligned, c_span, c_last_byte;
  logic                  c_err;
  logic [ADDR_WIDTH-1:0] b_bytes, wrap_inc, n_addr;
  logic                  beat_fire, cmd_fire;

  always_comb begin
    c_bytes     = ONE << cmd_size;
    c_beats     = ADDR_WIDTH'(cmd_len) + ONE;
    c_aligned   = cmd_addr & ~(c_bytes - ONE);
    c_span      = c_bytes * c_beats;
    c_last_byte = c_aligned + c_span - ONE;
    c_err       = 1'b0;
    if (cmd_burst == XBURST_RESERVED)
      c_err = 1'b1;
    if (c_bytes > ADDR_WIDTH'(STRB_W))
      c_err = 1'b1;
    if (cmd_burst == XBURST_WRAP &&
        !(cmd_len == LEN_WIDTH'(1) || cmd_len == LEN_WIDTH'(3) ||
          cmd_len == LEN_WIDTH'(7) || cmd_len == LEN_WIDTH'(15)))
      c_err = 1'b1;
    if (cmd_burst == XBURST_WRAP && (cmd_addr & (c_bytes - ONE)) != '0)
      c_err = 1'b1;
    if (cmd_burst == XBURST_INCR && ((c_last_byte ^ cmd_addr) >> 12) != '0)
      c_err = 1'b1;
    if (LEN_WIDTH > 4 && cmd_len > LEN_WIDTH'(15) && cmd_burst != XBURST_INCR)
      c_err = 1'b1;
  end

  // Beat n+1 is derived from the registered beat n address.
  always_comb begin
    b_bytes  = ONE << size_q;
    wrap_inc = beat_addr + b_bytes;
    case (burst_q)
      XBURST_INCR: n_addr = (beat_addr & ~(b_bytes - ONE)) + b_bytes;
      XBURST_WRAP: n_addr = (wrap_inc == lower_q + span_q) ? lower_q : wrap_inc;
      XBURST_FIXED: n_addr = beat_addr;
      default:     n_addr = beat_addr;
    endcase
  end

  assign beat_valid = (state == ACTIVE);
  assign beat_fire  = beat_valid && beat_ready;
  assign cmd_ready  = (state == IDLE) || (beat_fire && beat_last);
  assign cmd_fire   = cmd_valid && cmd_ready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      beat_addr <= '0;
      beat_strb <= '0;
      beat_last <= 1'b0;
      beat_idx  <= '0;
      beat_id   <= '0;
      beat_resp <= RESP_OKAY;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      lower_q   <= '0;
      span_q    <= '0;
    end else if (cmd_fire) begin
      state     <= ACTIVE;
      beat_addr <= cmd_addr;
      beat_strb <= c_err ? '0 : lane_strb(cmd_addr, c_bytes);
      beat_last <= (cmd_len == '0);
      beat_idx  <= '0;
      beat_id   <= cmd_id;
      beat_resp <= c_err ? RESP_SLVERR : RESP_OKAY;
      len_q     <= cmd_len;
      size_q    <= cmd_size;
      burst_q   <= cmd_burst;
      lower_q   <= cmd_addr & ~(c_span - ONE);
      span_q    <= c_span;
    end else if (beat_fire) begin
      if (beat_last) begin
        state <= IDLE;
      end else begin
        beat_addr <= n_addr;
        beat_strb <= (beat_resp == RESP_SLVERR) ? '0 : lane_strb(n_addr, b_bytes);
        beat_idx  <= beat_idx + LEN_WIDTH'(1);
        beat_last <= ((beat_idx + LEN_WIDTH'(1)) == len_q);
      end
    end
  end
endmodule

// File: tb/tb_axi3_burst_addr_gen.sv
// tb/tb_axi3_burst_addr_gen.sv - randomized bench for axi3_burst_addr_gen against a beat-list model
module tb_axi3_burst_addr_gen;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic        last;
    logic [3:0]  idx;
    logic [3:0]  id;
    logic [1:0]  resp;
    bit          chk_addr;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [3:0]  cmd_id;
  logic        beat_valid, beat_ready;
  logic [31:0] beat_addr;
  logic [3:0]  beat_strb;
  logic        beat_last;
  logic [3:0]  beat_idx;
  logic [3:0]  beat_id;
  logic [1:0]  beat_resp;

  int    n_vec = 0;
  int    n_bad = 0;
  bit    rand_ready = 0;
  bit    cmd_taken;
  beat_t q[$];
  beat_t bq[$];
  logic [31:0] ea[4];
  logic [3:0]  es[4];
  logic [31:0] ra, r;
  logic [3:0]  rl, ri;
  logic [2:0]  rs;
  logic [1:0]  rb;

  axi3_burst_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_strb(beat_strb), .beat_last(beat_last), .beat_idx(beat_idx),
    .beat_id(beat_id), .beat_resp(beat_resp)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Whole-burst model: each beat computed directly from its index.
  function automatic void gen(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [3:0] id, output beat_t out_q[$]);
    longint unsigned addr, bytes, n, aligned, span, lower, ba, off, cstart;
    bit    err;
    beat_t b;
    addr    = a;
    bytes   = 64'd1 << size;
    n       = longint'(len) + 1;
    aligned = addr - addr % bytes;
    span    = bytes * n;
    lower   = addr - addr % span;
    err = (burst == 2'b11) || (bytes > 4) ||
          (burst == 2'b10 && !(n inside {2, 4, 8, 16})) ||
          (burst == 2'b10 && addr % bytes != 0) ||
          (burst == 2'b01 && (aligned + n * bytes - 1) / 4096 != addr / 4096);
    out_q.delete();
    for (int k = 0; k < n; k++) begin
      if (burst == 2'b00)      ba = addr;
      else if (burst == 2'b10) ba = lower + (addr - lower + k * bytes) % span;
      else                     ba = (k == 0) ? addr : (aligned + k * bytes) % (64'd1 << 32);
      off    = ba % 4;
      cstart = off - off % bytes;
      for (int i = 0; i < 4; i++)
        b.strb[i] = !err && (i >= off) && (i < cstart + bytes);
      b.addr     = ba[31:0];
      b.last     = (k == n - 1);
      b.idx      = 4'(k);
      b.id       = id;
      b.resp     = err ? 2'b10 : 2'b00;
      b.chk_addr = !err;
      out_q.push_back(b);
    end
  endfunction

  // Runs at the falling edge: inputs are stable and the coming rising edge will sample them.
  task automatic monitor();
    beat_t nb[$];
    cmd_taken = 0;
    chk("cmd_ready", cmd_ready, (q.size() == 0) || (q[0].last && beat_ready));
    chk("beat_valid", beat_valid, q.size() != 0);
    if (q.size() != 0 && beat_valid) begin
      if (q[0].chk_addr) chk("beat_addr", beat_addr, q[0].addr);
      chk("beat_strb", beat_strb, q[0].strb);
      chk("beat_last", beat_last, q[0].last);
      chk("beat_idx", beat_idx, q[0].idx);
      chk("beat_id", beat_id, q[0].id);
      chk("beat_resp", beat_resp, q[0].resp);
      if (beat_ready) void'(q.pop_front());
    end
    if (cmd_valid && cmd_ready) begin
      gen(cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_id, nb);
      foreach (nb[k]) q.push_back(nb[k]);
      cmd_taken = 1;
    end
  endtask

  task automatic step();
    @(negedge ACLK);
    monitor();
    @(posedge ACLK);
    #1;
    if (rand_ready) beat_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                      input logic [1:0] b, input logic [3:0] i);
    cmd_valid = 1; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b; cmd_id = i;
    for (int t = 0; t < 300; t++) begin
      step();
      if (cmd_taken) begin
        cmd_valid = 0;
        return;
      end
    end
    chk("send_timeout", 1, 0);
    cmd_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && q.size() != 0; t++) step();
    chk("drain_timeout", q.size(), 0);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_beat_valid"}, beat_valid, 0);
    chk({tag, "_beat_last"}, beat_last, 0);
    chk({tag, "_beat_addr"}, beat_addr, 0);
    chk({tag, "_beat_strb"}, beat_strb, 0);
    chk({tag, "_beat_idx"}, beat_idx, 0);
    chk({tag, "_beat_id"}, beat_id, 0);
    chk({tag, "_beat_resp"}, beat_resp, 0);
  endtask

  task automatic pin_err(input string name, input logic [31:0] a, input logic [3:0] l,
                         input logic [2:0] s, input logic [1:0] b, input int nbeats);
    gen(a, l, s, b, 4'd0, bq);
    chk({name, "_n"}, bq.size(), nbeats);
    foreach (bq[k]) begin
      chk({name, "_resp"}, bq[k].resp, 2'b10);
      chk({name, "_strb"}, bq[k].strb, 4'b0000);
      chk({name, "_last"}, bq[k].last, k == nbeats - 1);
    end
  endtask

  initial begin
    ARESETn = 0; cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
    cmd_id = 0; beat_ready = 0;
    repeat (3) @(posedge ACLK);
    #1;
    check_reset_outputs("reset");
    @(negedge ACLK);
    ARESETn = 1;
    @(posedge ACLK);
    #1;

    // Pin the model with hand-computed bursts.
    gen(32'h1002, 4'd3, 3'd2, 2'b01, 4'd0, bq);
    ea = '{32'h1002, 32'h1004, 32'h1008, 32'h100C};
    es = '{4'b1100, 4'b1111, 4'b1111, 4'b1111};
    chk("pin_incr_n", bq.size(), 4);
    foreach (bq[k]) begin
      chk("pin_incr_addr", bq[k].addr, ea[k]);
      chk("pin_incr_strb", bq[k].strb, es[k]);
      chk("pin_incr_last", bq[k].last, k == 3);
      chk("pin_incr_resp", bq[k].resp, 2'b00);
    end
    gen(32'h34, 4'd3, 3'd2, 2'b10, 4'd0, bq);
    ea = '{32'h34, 32'h38, 32'h3C, 32'h30};
    chk("pin_wrap_n", bq.size(), 4);
    foreach (bq[k]) begin
      chk("pin_wrap_addr", bq[k].addr, ea[k]);
      chk("pin_wrap_strb", bq[k].strb, 4'b1111);
      chk("pin_wrap_last", bq[k].last, k == 3);
    end
    gen(32'h2001, 4'd2, 3'd0, 2'b00, 4'd0, bq);
    chk("pin_fixed_n", bq.size(), 3);
    foreach (bq[k]) begin
      chk("pin_fixed_addr", bq[k].addr, 32'h2001);
      chk("pin_fixed_strb", bq[k].strb, 4'b0010);
      chk("pin_fixed_idx", bq[k].idx, k);
    end
    pin_err("pin_err_4k", 32'h0FF8, 4'd3, 3'd2, 2'b01, 4);
    pin_err("pin_err_rsv", 32'h0100, 4'd3, 3'd2, 2'b11, 4);
    pin_err("pin_err_wraplen", 32'h0040, 4'd2, 3'd2, 2'b10, 3);

    // Directed bursts through the DUT.
    beat_ready = 1;
    send(32'h1002, 4'd3, 3'd2, 2'b01, 4'd1); drain();
    send(32'h34,   4'd3, 3'd2, 2'b10, 4'd2); drain();
    send(32'h2001, 4'd2, 3'd0, 2'b00, 4'd3); drain();
    send(32'h0FF8, 4'd3, 3'd2, 2'b01, 4'd4); drain();
    send(32'h0100, 4'd3, 3'd2, 2'b11, 4'd5); drain();
    send(32'h0040, 4'd2, 3'd2, 2'b10, 4'd6); drain();
    send(32'h0500, 4'd0, 3'd1, 2'b01, 4'd7); drain();

    // Backpressure mid-burst, then a second command handed over on the last beat.
    send(32'h0200, 4'd3, 3'd2, 2'b01, 4'd8);
    step();
    beat_ready = 0;
    repeat (3) step();
    beat_ready = 1;
    send(32'h0034, 4'd3, 3'd2, 2'b10, 4'd9);
    drain();

    // Asynchronous reset during beat 1 of a len=7 INCR.
    send(32'h0300, 4'd7, 3'd2, 2'b01, 4'hA);
    step();
    ARESETn = 0;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    @(negedge ACLK);
    ARESETn = 1;
    @(posedge ACLK);
    #1;
    step();
    send(32'h0404, 4'd3, 3'd2, 2'b01, 4'hB);
    drain();

    // Randomized traffic with random backpressure and idle gaps.
    rand_ready = 1;
    for (int c = 0; c < 200; c++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: ra = r;
        1: ra = (r & 32'hFFFF_F000) | 32'h0000_0FC0 | (r & 32'h3F);
        2: ra = r & 32'hFF;
        default: ra = r & 32'hFFFF_FFF0;
      endcase
      rb = 2'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 3));
      rl = 4'($urandom_range(0, 15));
      ri = 4'($urandom_range(0, 15));
      if (rb == 2'b10 && $urandom_range(0, 1) == 1) rl = 4'((1 << $urandom_range(1, 4)) - 1);
      send(ra, rl, rs, rb, ri);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) step();
    end
    rand_ready = 0;
    beat_ready = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
